// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding and default constants for the MEM-stage access unit
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'h0000_0000;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/ack bus between the access unit and memory
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_wren;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_wren, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_wren, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts BUSY cycles without ack and flags the final allowed cycle
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    // Saturates at TIMEOUT_CYCLES so a stray enable can never wrap back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != W'(TIMEOUT_CYCLES)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer between EX_MEM and the data memory
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                MEM_MEM_WREN,
    input  logic                MEM_MEM_RDEN,
    input  logic [31:0]         MEM_ALUResult,
    input  logic [31:0]         MEM_WriteData,
    mem_access_unit_if.master   mem,
    output logic [31:0]         MEM_ReadData,
    output logic                MEM_Stall,
    output logic                MEM_AddrErr,
    output logic                MEM_BusErr
);
    mau_state_t state, state_next;
    logic access, aligned, start, cnt_clear, cnt_enable, expired, timeout;
    logic stall_raw, addr_err_raw;

    assign access  = (MEM_MEM_WREN | MEM_MEM_RDEN) & ~flush;
    assign aligned = (MEM_ALUResult[1:0] == 2'b00);
    // Ack takes priority over an expiring counter in the same cycle.
    assign timeout = (state == BUSY) & ~mem.dmem_ack & expired;

    mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_comb begin
        state_next   = state;
        stall_raw    = 1'b0;
        addr_err_raw = 1'b0;
        start        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        start      = 1'b1;
                        stall_raw  = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = BUSY;
                    end else begin
                        addr_err_raw = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_raw = 1'b1;
                if (mem.dmem_ack || expired) begin
                    state_next = DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational flags are masked while reset is held, since inputs may still look like an access.
    assign MEM_Stall   = stall_raw & ~reset;
    assign MEM_AddrErr = addr_err_raw & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mem.dmem_req   <= 1'b0;
            mem.dmem_wren  <= 1'b0;
            mem.dmem_addr  <= '0;
            mem.dmem_wdata <= '0;
            MEM_ReadData   <= '0;
            MEM_BusErr     <= 1'b0;
        end else begin
            state      <= state_next;
            MEM_BusErr <= timeout;
            if (start) begin
                mem.dmem_req   <= 1'b1;
                mem.dmem_wren  <= MEM_MEM_WREN;
                mem.dmem_addr  <= MEM_ALUResult;
                mem.dmem_wdata <= MEM_WriteData;
            end else if (state == BUSY && mem.dmem_ack) begin
                mem.dmem_req <= 1'b0;
                if (!mem.dmem_wren) begin
                    MEM_ReadData <= mem.dmem_rdata;
                end
            end else if (timeout) begin
                mem.dmem_req <= 1'b0;
                MEM_ReadData <= ERR_RDATA;
            end
        end
    end
endmodule
